nco_phase_accum_mc: RTL and testbench

Multi-channel, parametrised phase accumulator for the NCO datapath. It is the successor to the single-channel 32-bit accumulator.
- Runs CH independent accumulators of N bits, each with its own frequency control word (FCW) and phase offset.
- FCW and offset are double-buffered and swapped into use by a single update strobe, so all channels change together.
- Adds a phase-sync clear, per-channel wrap flags and a valid-qualified, truncated phase output that feeds the phase-to-amplitude quantizer.

---
 rtl/nco_phase_accum_mc.sv | 102 ++++++++++
 tb/tb_nco_phase_accum_mc.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_phase_accum_mc.sv
// rtl/nco_phase_accum_mc.sv - multi-channel NCO phase accumulator
// Double-buffered FCW/offset per channel, phase-sync clear, truncated phase output with wrap flags.
module nco_phase_accum_mc #(
  parameter int N  = 32,
  parameter int P  = 12,
  parameter int CH = 4,
  localparam int CW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            sync,
  input  logic            cfg_we,
  input  logic            cfg_sel,
  input  logic [CW-1:0]   cfg_ch,
  input  logic [N-1:0]    cfg_data,
  input  logic            cfg_update,
  output logic [CH*P-1:0] phase_out,
  output logic [CH-1:0]   wrap,
  output logic            out_valid
);

  logic [N-1:0]    fcw_sh_q [CH];
  logic [N-1:0]    fcw_sh_d [CH];
  logic [N-1:0]    off_sh_q [CH];
  logic [N-1:0]    off_sh_d [CH];
  logic [N-1:0]    fcw_q    [CH];
  logic [N-1:0]    fcw_d    [CH];
  logic [N-1:0]    off_q    [CH];
  logic [N-1:0]    off_d    [CH];
  logic [N-1:0]    acc_q    [CH];
  logic [N-1:0]    acc_d    [CH];
  logic [CH-1:0]   carry_q, carry_d;
  logic            v1_q, v1_d;
  logic [CH*P-1:0] phase_q, phase_d;
  logic [CH-1:0]   wrap_q, wrap_d;
  logic            valid_q, valid_d;
  logic            cfg_ch_ok;

  // Widened compare so a non-power-of-two CH rejects the unused channel codes.
  assign cfg_ch_ok = (int'(cfg_ch) < CH);

  always_comb begin
    carry_d = carry_q;
    phase_d = '0;
    v1_d    = en && !sync;
    for (int c = 0; c < CH; c++) begin
      fcw_sh_d[c] = fcw_sh_q[c];
      off_sh_d[c] = off_sh_q[c];
      if (cfg_we && cfg_ch_ok && (int'(cfg_ch) == c)) begin
        if (cfg_sel) off_sh_d[c] = cfg_data;
        else         fcw_sh_d[c] = cfg_data;
      end
      // Update copies the pre-write shadow; accumulate below still sees the old fcw.
      fcw_d[c] = cfg_update ? fcw_sh_q[c] : fcw_q[c];
      off_d[c] = cfg_update ? off_sh_q[c] : off_q[c];

      acc_d[c] = acc_q[c];
      if (sync) begin
        acc_d[c]   = '0;
        carry_d[c] = 1'b0;
      end else if (en) begin
        {carry_d[c], acc_d[c]} = {1'b0, acc_q[c]} + {1'b0, fcw_q[c]};
      end

      phase_d[c*P +: P] = P'((acc_q[c] + off_q[c]) >> (N - P));
    end
    wrap_d  = carry_q & {CH{v1_q}};
    valid_d = v1_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fcw_sh_q <= '{default: '0};
      off_sh_q <= '{default: '0};
      fcw_q    <= '{default: '0};
      off_q    <= '{default: '0};
      acc_q    <= '{default: '0};
      carry_q  <= '0;
      v1_q     <= 1'b0;
      phase_q  <= '0;
      wrap_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      fcw_sh_q <= fcw_sh_d;
      off_sh_q <= off_sh_d;
      fcw_q    <= fcw_d;
      off_q    <= off_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      v1_q     <= v1_d;
      phase_q  <= phase_d;
      wrap_q   <= wrap_d;
      valid_q  <= valid_d;
    end
  end

  assign phase_out = phase_q;
  assign wrap      = wrap_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_nco_phase_accum_mc.sv
// tb/tb_nco_phase_accum_mc.sv - self-checking bench for nco_phase_accum_mc
// CH = 3 so that cfg_ch = 3 is an encodable but out-of-range channel.
module tb_nco_phase_accum_mc;
  localparam int N  = 32;
  localparam int P  = 12;
  localparam int CH = 3;
  localparam int CW = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            en = 1'b0;
  logic            sync = 1'b0;
  logic            cfg_we = 1'b0;
  logic            cfg_sel = 1'b0;
  logic [CW-1:0]   cfg_ch = '0;
  logic [N-1:0]    cfg_data = '0;
  logic            cfg_update = 1'b0;
  logic [CH*P-1:0] phase_out;
  logic [CH-1:0]   wrap;
  logic            out_valid;

  int checks = 0;
  int errors = 0;

  // Reference model: phase state as plain modulo-2^N numbers.
  logic [N-1:0]    m_fcw_sh [CH];
  logic [N-1:0]    m_off_sh [CH];
  logic [N-1:0]    m_fcw    [CH];
  logic [N-1:0]    m_off    [CH];
  logic [N-1:0]    m_acc    [CH];
  logic [CH-1:0]   m_carry;
  logic            m_v1;
  logic [CH*P-1:0] e_phase;
  logic [CH-1:0]   e_wrap;
  logic            e_valid;

  nco_phase_accum_mc #(.N(N), .P(P), .CH(CH)) dut (
    .clk(clk), .reset(reset), .en(en), .sync(sync),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_ch(cfg_ch), .cfg_data(cfg_data),
    .cfg_update(cfg_update), .phase_out(phase_out), .wrap(wrap), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [P-1:0] ph(input logic [CH*P-1:0] v, input int c);
    return v[c*P +: P];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_fcw_sh[c] = '0; m_off_sh[c] = '0; m_fcw[c] = '0; m_off[c] = '0; m_acc[c] = '0;
    end
    m_carry = '0; m_v1 = 1'b0;
    e_phase = '0; e_wrap = '0; e_valid = 1'b0;
  endtask

  task automatic model_edge();
    logic [63:0]  s;
    logic [N-1:0] t;
    if (reset) begin
      model_reset();
      return;
    end
    for (int c = 0; c < CH; c++) begin
      t = m_acc[c] + m_off[c];
      e_phase[c*P +: P] = t[N-1:N-P];
      e_wrap[c] = m_carry[c] & m_v1;
    end
    e_valid = m_v1;
    if (sync) begin
      for (int c = 0; c < CH; c++) m_acc[c] = '0;
      m_carry = '0;
      m_v1 = 1'b0;
    end else if (en) begin
      for (int c = 0; c < CH; c++) begin
        s = 64'(m_acc[c]) + 64'(m_fcw[c]);
        m_carry[c] = (s > 64'hFFFF_FFFF);
        m_acc[c] = s[31:0];
      end
      m_v1 = 1'b1;
    end else begin
      m_v1 = 1'b0;
    end
    if (cfg_update)
      for (int c = 0; c < CH; c++) begin
        m_fcw[c] = m_fcw_sh[c];
        m_off[c] = m_off_sh[c];
      end
    if (cfg_we && int'(cfg_ch) < CH) begin
      if (cfg_sel) m_off_sh[cfg_ch] = cfg_data;
      else         m_fcw_sh[cfg_ch] = cfg_data;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cfg_write(input logic sel, input int ch, input logic [N-1:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_ch = CW'(ch); cfg_data = data;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (phase_out !== '0) begin errors++; $display("FAIL reset_phase got %h want 0", phase_out); end
    checks++; if (wrap !== '0) begin errors++; $display("FAIL reset_wrap got %b want 0", wrap); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    model_reset();
    reset = 1'b0;
  endtask

  task automatic test_ramp();
    logic [P-1:0] exp;
    cfg_write(1'b0, 0, 32'h1000_0000);
    cfg_update = 1'b1; step(); cfg_update = 1'b0;
    en = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ramp_latency got %b want 0", out_valid); end
    for (int k = 1; k <= 16; k++) begin
      step();
      exp = P'(k * 256);
      checks++; if (ph(phase_out, 0) !== exp) begin errors++; $display("FAIL ramp_phase k=%0d got %h want %h", k, ph(phase_out, 0), exp); end
      checks++; if (wrap[0] !== (k == 16)) begin errors++; $display("FAIL ramp_wrap k=%0d got %b want %b", k, wrap[0], k == 16); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ramp_valid k=%0d got %b want 1", k, out_valid); end
      checks++; if ({phase_out, wrap, out_valid} !== {e_phase, e_wrap, e_valid}) begin errors++; $display("FAIL ramp_model got %h/%b/%b want %h/%b/%b", phase_out, wrap, out_valid, e_phase, e_wrap, e_valid); end
    end
  endtask

  task automatic test_offset();
    cfg_write(1'b0, 1, 32'h0000_0000);
    cfg_write(1'b1, 1, 32'h8000_0000);
    cfg_update = 1'b1; step(); cfg_update = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++; if (ph(phase_out, 1) !== 12'h800) begin errors++; $display("FAIL offset_phase k=%0d got %h want 800", k, ph(phase_out, 1)); end
      checks++; if (wrap[1] !== 1'b0) begin errors++; $display("FAIL offset_wrap k=%0d got %b want 0", k, wrap[1]); end
      checks++; if ({phase_out, wrap, out_valid} !== {e_phase, e_wrap, e_valid}) begin errors++; $display("FAIL offset_model got %h/%b/%b want %h/%b/%b", phase_out, wrap, out_valid, e_phase, e_wrap, e_valid); end
    end
  endtask

  task automatic test_double_buffer();
    logic [P-1:0] prev;
    logic [P-1:0] d;
    cfg_write(1'b0, 2, 32'h0100_0000);
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (ph(phase_out, 2) !== 12'h000) begin errors++; $display("FAIL dbuf_static k=%0d got %h want 000", k, ph(phase_out, 2)); end
    end
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_ch = 2'd2; cfg_data = 32'h0200_0000; cfg_update = 1'b1;
    step();
    cfg_we = 1'b0; cfg_update = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      repeat (2) begin
        step();
        checks++; if ({phase_out, wrap, out_valid} !== {e_phase, e_wrap, e_valid}) begin errors++; $display("FAIL dbuf_model got %h/%b/%b want %h/%b/%b", phase_out, wrap, out_valid, e_phase, e_wrap, e_valid); end
      end
      for (int k = 0; k < 5; k++) begin
        prev = ph(phase_out, 2);
        step();
        d = ph(phase_out, 2) - prev;
        checks++; if (d !== (pass == 0 ? 12'h010 : 12'h020)) begin errors++; $display("FAIL dbuf_step pass=%0d got %h want %h", pass, d, pass == 0 ? 12'h010 : 12'h020); end
      end
      cfg_update = 1'b1; step(); cfg_update = 1'b0;
    end
  endtask

  task automatic test_sync();
    cfg_write(1'b1, 0, 32'h0340_0000);
    cfg_update = 1'b1; step(); cfg_update = 1'b0;
    repeat (5) step();
    sync = 1'b1; step(); sync = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sync_valid got %b want 0", out_valid); end
    checks++; if (ph(phase_out, 0) !== 12'h034) begin errors++; $display("FAIL sync_phase got %h want 034", ph(phase_out, 0)); end
    step();
    checks++; if (ph(phase_out, 0) !== 12'h134) begin errors++; $display("FAIL sync_resume got %h want 134", ph(phase_out, 0)); end
    checks++; if ({phase_out, wrap, out_valid} !== {e_phase, e_wrap, e_valid}) begin errors++; $display("FAIL sync_model got %h/%b/%b want %h/%b/%b", phase_out, wrap, out_valid, e_phase, e_wrap, e_valid); end
  endtask

  task automatic test_stall();
    logic [P-1:0] hold;
    step();
    en = 1'b0;
    step();
    hold = ph(phase_out, 0);
    for (int k = 0; k < 3; k++) begin
      if (k == 2) en = 1'b1;
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_valid k=%0d got %b want 0", k, out_valid); end
      checks++; if (ph(phase_out, 0) !== hold) begin errors++; $display("FAIL stall_hold k=%0d got %h want %h", k, ph(phase_out, 0), hold); end
    end
    step();
    checks++; if (ph(phase_out, 0) !== P'(hold + 12'h100)) begin errors++; $display("FAIL stall_resume got %h want %h", ph(phase_out, 0), P'(hold + 12'h100)); end

    // Descending phase: FCW of all ones, with sync and update in the same cycle.
    cfg_write(1'b0, 0, 32'hFFFF_FFFF);
    cfg_write(1'b1, 0, 32'h0000_0000);
    cfg_update = 1'b1; sync = 1'b1; step(); cfg_update = 1'b0; sync = 1'b0;
    step();
    checks++; if (ph(phase_out, 0) !== 12'h000 || out_valid !== 1'b0) begin errors++; $display("FAIL desc_sync got %h/%b want 000/0", ph(phase_out, 0), out_valid); end
    step();
    checks++; if (ph(phase_out, 0) !== 12'hFFF || wrap[0] !== 1'b0) begin errors++; $display("FAIL desc_first got %h/%b want fff/0", ph(phase_out, 0), wrap[0]); end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (ph(phase_out, 0) !== 12'hFFF || wrap[0] !== 1'b1) begin errors++; $display("FAIL desc_wrap k=%0d got %h/%b want fff/1", k, ph(phase_out, 0), wrap[0]); end
      checks++; if ({phase_out, wrap, out_valid} !== {e_phase, e_wrap, e_valid}) begin errors++; $display("FAIL desc_model got %h/%b/%b want %h/%b/%b", phase_out, wrap, out_valid, e_phase, e_wrap, e_valid); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      en         = ($urandom_range(0, 3) != 0);
      sync       = ($urandom_range(0, 15) == 0);
      cfg_we     = ($urandom_range(0, 2) == 0);
      cfg_sel    = 1'($urandom_range(0, 1));
      cfg_ch     = CW'($urandom_range(0, 3));
      cfg_data   = ($urandom_range(0, 1) != 0) ? $urandom : (32'($urandom_range(1, 255)) << 24);
      cfg_update = ($urandom_range(0, 7) == 0);
      step();
      checks++; if ({phase_out, wrap, out_valid} !== {e_phase, e_wrap, e_valid}) begin errors++; $display("FAIL random k=%0d got %h/%b/%b want %h/%b/%b", k, phase_out, wrap, out_valid, e_phase, e_wrap, e_valid); end
    end
    en = 1'b0; sync = 1'b0; cfg_we = 1'b0; cfg_update = 1'b0;
  endtask

  task automatic test_reset_mid();
    cfg_write(1'b0, 0, 32'h1234_5678);
    cfg_update = 1'b1; en = 1'b1; step(); cfg_update = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    #1;
    checks++; if (phase_out !== '0) begin errors++; $display("FAIL rstmid_phase got %h want 0", phase_out); end
    checks++; if (wrap !== '0) begin errors++; $display("FAIL rstmid_wrap got %b want 0", wrap); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", out_valid); end
    model_reset();
    #2 reset = 1'b0;
    en = 1'b0;
    cfg_write(1'b0, 3, 32'hFFFF_FFFF);
    cfg_write(1'b1, 3, 32'h8000_0000);
    cfg_update = 1'b1; step(); cfg_update = 1'b0;
    en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++; if (phase_out !== '0 || wrap !== '0) begin errors++; $display("FAIL oob_write k=%0d got %h/%b want 0/0", k, phase_out, wrap); end
      checks++; if ({phase_out, wrap, out_valid} !== {e_phase, e_wrap, e_valid}) begin errors++; $display("FAIL oob_model got %h/%b/%b want %h/%b/%b", phase_out, wrap, out_valid, e_phase, e_wrap, e_valid); end
    end
    en = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_ramp();
    test_offset();
    test_double_buffer();
    test_sync();
    test_stall();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
